branch_resolve_unit: RTL and testbench

Execute-stage branch resolution and predictor-update block: the consumer end of the fetch stage's prediction interface. Latches the fetch-time prediction tags (prediction, BTB hit, GHR snapshot, PC low bits) from decode into execute alongside each beq/bne, compares them with the actual outcome, and drives the fetch stage's update, recovery and flush controls. Sits between the ID/EX boundary and the fetch stage, in parallel with the EX datapath.

---
 rtl/branch_resolve_unit.sv | 158 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-stage branch resolution and predictor-update control. Captures the
// fetch-time prediction tags of each beq/bne as it moves from decode into
// execute. It compares the prediction with the real outcome from the EX
// comparator and drives the fetch stage's redirect, flush and update controls.
//
// Optional feature: define BRU_STATS_EN to build saturating branch and
// mispredict counters. When it is undefined, the counter ports read 0.
//
// Ports
//   clk, reset               rising-edge clock, async active-high reset
//   ID_EX_write              1 = advance D->E, 0 = hold E state (stall)
//   flush_in                 external squash of the D-stage instruction
//   opcode_D                 decode opcode (beq 6'b000100, bne 6'b000101)
//   prediction_D, hit_D      fetch-time direction prediction / BTB hit
//   GHR_D, Pc_D              fetch-time history snapshot / PC low bits
//   zero_E                   EX comparator result, rs == rt
//   branch_E, bne_E          one pulse per resolving beq / bne
//   real_Value_E             actual direction of the resolving branch
//   Pc_E, Pc_Xor_GR_E        E-stage PC and PC ^ GHR predictor index
//   selectCorrectTarget      redirect to the BTB target read at Pc_E
//   selectCorrectPcPlus1     redirect to Pc_E + 1
//   select_hit               either redirect is active
//   flush, flush_hit         squash IF/ID (not-taken / taken mispredict)
//   mispredict_count,
//   branch_count             statistics (BRU_STATS_EN only)
//   fsm_state_o              debug view of the RUN/RECOVER state
//
// Handshake: this block has no valid/ready pair. ID_EX_write acts as the
// stage-advance enable. The resolve outputs are combinational and valid
// only in the cycle they pulse.
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int PC_W  = 5,
    parameter int GHR_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_write,
    input  logic             flush_in,
    input  logic [5:0]       opcode_D,
    input  logic             prediction_D,
    input  logic             hit_D,
    input  logic [GHR_W-1:0] GHR_D,
    input  logic [PC_W-1:0]  Pc_D,
    input  logic             zero_E,
    output logic             branch_E,
    output logic             bne_E,
    output logic             real_Value_E,
    output logic [PC_W-1:0]  Pc_E,
    output logic [GHR_W-1:0] Pc_Xor_GR_E,
    output logic             selectCorrectTarget,
    output logic             select_hit,
    output logic             selectCorrectPcPlus1,
    output logic             flush,
    output logic             flush_hit,
    output logic [CNT_W-1:0] mispredict_count,
    output logic [CNT_W-1:0] branch_count,
    output logic             fsm_state_o
);

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic               is_bne_q, pred_q, hit_q, fired_q, fired_d;
    logic [GHR_W-1:0]   ghr_q;
    logic [PC_W-1:0]    pc_q;

    logic fire, real_taken, redir, mis_nt, mis_t, mispredict, is_branch_D;

    assign is_branch_D = (opcode_D == OP_BEQ) || (opcode_D == OP_BNE);

    // In RECOVER, E holds the wrong-path bubble, so nothing may resolve.
    assign fire       = valid_q && !fired_q && (state_q == RUN);
    assign real_taken = is_bne_q ? !zero_E : zero_E;
    // Fetch only left the sequential path when it predicted taken and had a target.
    assign redir      = pred_q && hit_q;
    assign mis_nt     = fire && redir && !real_taken;
    assign mis_t      = fire && !redir && real_taken;
    assign mispredict = mis_nt || mis_t;

    assign branch_E             = fire && !is_bne_q;
    assign bne_E                = fire && is_bne_q;
    assign real_Value_E         = fire && real_taken;
    assign selectCorrectPcPlus1 = mis_nt;
    assign flush                = mis_nt;
    assign selectCorrectTarget  = mis_t;
    assign flush_hit            = mis_t;
    assign select_hit           = mispredict;

    assign Pc_E        = pc_q;
    assign Pc_Xor_GR_E = pc_q[GHR_W-1:0] ^ ghr_q;
    assign fsm_state_o = state_q;

    always_comb begin
        state_d = (state_q == RUN) ? (mispredict ? RECOVER : RUN) : RUN;
        // A mispredict squashes the D instruction, so it enters E as a bubble.
        valid_d = is_branch_D && !flush_in && !mispredict;
        // While stalled, remember that this branch already resolved once.
        fired_d = fired_q || fire;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            valid_q  <= 1'b0;
            is_bne_q <= 1'b0;
            pred_q   <= 1'b0;
            hit_q    <= 1'b0;
            fired_q  <= 1'b0;
            ghr_q    <= '0;
            pc_q     <= '0;
        end else begin
            state_q <= state_d;
            if (ID_EX_write) begin
                valid_q  <= valid_d;
                is_bne_q <= (opcode_D == OP_BNE);
                pred_q   <= prediction_D;
                hit_q    <= hit_D;
                ghr_q    <= GHR_D;
                pc_q     <= Pc_D;
                fired_q  <= 1'b0;
            end else begin
                fired_q  <= fired_d;
            end
        end
    end

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (fire && (br_cnt_q != '1))
                br_cnt_q <= br_cnt_q + 1'b1;
            if (mispredict && (mis_cnt_q != '1))
                mis_cnt_q <= mis_cnt_q + 1'b1;
        end
    end

    assign branch_count     = br_cnt_q;
    assign mispredict_count = mis_cnt_q;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_EX_write;
  logic        flush_in;
  logic [5:0]  opcode_D;
  logic        prediction_D, hit_D;
  logic [3:0]  GHR_D;
  logic [4:0]  Pc_D;
  logic        zero_E;
  logic        branch_E, bne_E, real_Value_E;
  logic [4:0]  Pc_E;
  logic [3:0]  Pc_Xor_GR_E;
  logic        selectCorrectTarget, select_hit, selectCorrectPcPlus1;
  logic        flush, flush_hit;
  logic [15:0] mispredict_count, branch_count;
  logic        fsm_state_o;

  int checks = 0;
  int errors = 0;

  // clock/reset block
  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .ID_EX_write(ID_EX_write), .flush_in(flush_in),
    .opcode_D(opcode_D), .prediction_D(prediction_D), .hit_D(hit_D),
    .GHR_D(GHR_D), .Pc_D(Pc_D), .zero_E(zero_E),
    .branch_E(branch_E), .bne_E(bne_E), .real_Value_E(real_Value_E),
    .Pc_E(Pc_E), .Pc_Xor_GR_E(Pc_Xor_GR_E),
    .selectCorrectTarget(selectCorrectTarget), .select_hit(select_hit),
    .selectCorrectPcPlus1(selectCorrectPcPlus1), .flush(flush),
    .flush_hit(flush_hit), .mispredict_count(mispredict_count),
    .branch_count(branch_count), .fsm_state_o(fsm_state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // order: branch_E bne_E real sel_target sel_hit sel_pc1 flush flush_hit
  task automatic chk_res(input string tag, input logic [7:0] exp);
    chk({tag, ".outs"},
        {24'd0, branch_E, bne_E, real_Value_E, selectCorrectTarget,
         select_hit, selectCorrectPcPlus1, flush, flush_hit},
        {24'd0, exp});
  endtask

  // driver: present an instruction in D for the next edge
  task automatic load_d(input logic [5:0] op, input logic p, input logic h,
                        input logic [3:0] g, input logic [4:0] pc, input logic fl);
    @(negedge clk);
    opcode_D = op; prediction_D = p; hit_D = h; GHR_D = g; Pc_D = pc; flush_in = fl;
  endtask

  // driver: E-stage cycle, D holds a nop, comparator result applied
  task automatic resolve(input logic z);
    @(negedge clk);
    opcode_D = 6'd0; prediction_D = 1'b0; hit_D = 1'b0; GHR_D = 4'd0; Pc_D = 5'd0;
    flush_in = 1'b0; zero_E = z;
    #1;
  endtask

  initial begin
    reset = 1'b1; ID_EX_write = 1'b1; flush_in = 1'b0; opcode_D = 6'd0;
    prediction_D = 1'b0; hit_D = 1'b0; GHR_D = 4'd0; Pc_D = 5'd0; zero_E = 1'b0;
    #12;
    chk_res("reset", 8'b0000_0000);
    chk("reset.pc", {27'd0, Pc_E}, 32'd0);
    chk("reset.state", {31'd0, fsm_state_o}, 32'd0);
    chk("reset.bcnt", {16'd0, branch_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // beq predicted taken with hit, actually taken: correct
    load_d(BEQ, 1'b1, 1'b1, 4'd0, 5'd3, 1'b0);
    resolve(1'b1);
    chk_res("beq_ok", 8'b1010_0000);
    chk("beq_ok.state", {31'd0, fsm_state_o}, 32'd0);
    resolve(1'b1);
    chk_res("beq_ok.after", 8'b0000_0000);
    chk("beq_ok.state2", {31'd0, fsm_state_o}, 32'd0);

    // bne predicted taken with hit, operands equal: not-taken mispredict
    load_d(BNE, 1'b1, 1'b1, 4'd0, 5'd4, 1'b0);
    resolve(1'b1);
    chk_res("bne_mis", 8'b0100_1110);
    resolve(1'b1);
    chk_res("bne_mis.recover", 8'b0000_0000);
    chk("bne_mis.state", {31'd0, fsm_state_o}, 32'd1);
    resolve(1'b1);
    chk("bne_mis.back", {31'd0, fsm_state_o}, 32'd0);

    // beq predicted taken without BTB hit, taken: taken mispredict
    load_d(BEQ, 1'b1, 1'b0, 4'b0011, 5'd9, 1'b0);
    resolve(1'b1);
    chk_res("beq_tmis", 8'b1011_1001);
    chk("beq_tmis.pc", {27'd0, Pc_E}, 32'd9);
    chk("beq_tmis.xor", {28'd0, Pc_Xor_GR_E}, 32'b1010);
    resolve(1'b1);
    chk_res("beq_tmis.recover", 8'b0000_0000);
    chk("beq_tmis.state", {31'd0, fsm_state_o}, 32'd1);
    resolve(1'b0);

    // beq predicted not-taken, not taken, stalled for 3 cycles
    load_d(BEQ, 1'b0, 1'b0, 4'd0, 5'd12, 1'b0);
    resolve(1'b0);
    ID_EX_write = 1'b0;
    chk_res("stall.c1", 8'b1000_0000);
    @(negedge clk); #1;
    chk_res("stall.c2", 8'b0000_0000);
    @(negedge clk); #1;
    chk_res("stall.c3", 8'b0000_0000);
    ID_EX_write = 1'b1;
    resolve(1'b0);
    chk_res("stall.after", 8'b0000_0000);

    // beq squashed in D by flush_in
    load_d(BEQ, 1'b0, 1'b0, 4'b0101, 5'd22, 1'b1);
    resolve(1'b1);
    chk_res("flush_in", 8'b0000_0000);
    chk("flush_in.pc", {27'd0, Pc_E}, 32'd22);
    chk("flush_in.xor", {28'd0, Pc_Xor_GR_E}, 32'b0011);

    // bne predicted not-taken with hit, operands equal: correct not taken
    load_d(BNE, 1'b0, 1'b1, 4'd0, 5'd1, 1'b0);
    resolve(1'b1);
    chk_res("bne_ok", 8'b0100_0000);

    // bne predicted not-taken, operands differ: taken mispredict
    load_d(BNE, 1'b0, 1'b0, 4'b1111, 5'd31, 1'b0);
    resolve(1'b0);
    chk_res("bne_tmis", 8'b0111_1001);
    chk("bne_tmis.xor", {28'd0, Pc_Xor_GR_E}, 32'b0000);
    resolve(1'b0);
    chk_res("bne_tmis.recover", 8'b0000_0000);
    resolve(1'b0);

    // 6 branches resolved so far, 3 of them mispredicted
`ifdef BRU_STATS_EN
    chk("stats.bcnt", {16'd0, branch_count}, 32'd6);
    chk("stats.mcnt", {16'd0, mispredict_count}, 32'd3);
`else
    chk("stats.bcnt", {16'd0, branch_count}, 32'd0);
    chk("stats.mcnt", {16'd0, mispredict_count}, 32'd0);
`endif

    // reset in the middle of a mispredict resolution
    load_d(BNE, 1'b1, 1'b1, 4'hf, 5'd17, 1'b0);
    resolve(1'b1);
    chk_res("rst_mid.pre", 8'b0100_1110);
    reset = 1'b1;
    #1;
    chk_res("rst_mid", 8'b0000_0000);
    chk("rst_mid.pc", {27'd0, Pc_E}, 32'd0);
    chk("rst_mid.state", {31'd0, fsm_state_o}, 32'd0);
    chk("rst_mid.bcnt", {16'd0, branch_count}, 32'd0);
    chk("rst_mid.mcnt", {16'd0, mispredict_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    resolve(1'b1);
    chk_res("rst_mid.after", 8'b0000_0000);
    chk("rst_mid.state2", {31'd0, fsm_state_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
